// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous RAM (word addressed, 1-cycle read
// latency) between the CPU instruction-fetch port and the CPU load/store
// port. One access is in flight at a time:
//   IDLE  -> pick a winner, register the RAM command and the winner's ack
//   ISSUE -> command is on the RAM bus; writes return to IDLE afterwards
//   RESP  -> RAM read data is forwarded combinationally to the owner
// Data accesses win ties, but after STARVE_MAX back-to-back data grants
// with a fetch waiting, the fetch is forced through.
//
// Optional feature (compile-time macro MEM_ARB_WRCNT_EN): adds parameter
// CNT_W and output led_num, a wrapping count of granted stores.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   if_req/if_addr           fetch request, held until if_ack
//   if_ack/if_rvalid/if_rdata  fetch accept pulse, data-valid pulse, data
//   d_req/d_we/d_addr/d_wdata  data request, held until d_ack
//   d_ack/d_rvalid/d_rdata   data accept pulse, load-data-valid pulse, data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  RAM macro interface
//   busy                     high whenever an access is in progress
//   led_num                  store count (only with MEM_ARB_WRCNT_EN)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int MW         = 6,
  parameter int STARVE_MAX = 4
`ifdef MEM_ARB_WRCNT_EN
  ,parameter int CNT_W     = 8
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_ack,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_ack,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [MW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
`ifdef MEM_ARB_WRCNT_EN
  ,output logic [CNT_W-1:0] led_num
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t        state_reg, state_next;
  owner_t        owner_reg, owner_next;
  logic [3:0]    starve_reg, starve_next;
  logic          mem_en_reg, mem_en_next;
  logic          mem_we_reg, mem_we_next;
  logic [MW-1:0] mem_addr_reg, mem_addr_next;
  logic [31:0]   mem_wdata_reg, mem_wdata_next;
  logic          if_ack_reg, if_ack_next;
  logic          d_ack_reg, d_ack_next;
  logic [31:0]   if_hold_reg, if_hold_next;
  logic [31:0]   d_hold_reg, d_hold_next;
  logic          data_win;
`ifdef MEM_ARB_WRCNT_EN
  logic [CNT_W-1:0] wrcnt_reg, wrcnt_next;
`endif

  // Byte-offset bits and bits above the RAM depth are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:MW+2], if_addr[1:0],
                              d_addr[31:MW+2], d_addr[1:0]};

  // Data wins unless a waiting fetch has already been passed over
  // STARVE_MAX times in a row.
  assign data_win = d_req && !(if_req && (starve_reg == STARVE_LIM));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      owner_reg     <= OWN_IF;
      starve_reg    <= '0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_ack_reg    <= 1'b0;
      d_ack_reg     <= 1'b0;
      if_hold_reg   <= '0;
      d_hold_reg    <= '0;
`ifdef MEM_ARB_WRCNT_EN
      wrcnt_reg     <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      starve_reg    <= starve_next;
      mem_en_reg    <= mem_en_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if_ack_reg    <= if_ack_next;
      d_ack_reg     <= d_ack_next;
      if_hold_reg   <= if_hold_next;
      d_hold_reg    <= d_hold_next;
`ifdef MEM_ARB_WRCNT_EN
      wrcnt_reg     <= wrcnt_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    starve_next    = starve_reg;
    mem_en_next    = 1'b0;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    if_ack_next    = 1'b0;
    d_ack_next     = 1'b0;
    if_hold_next   = if_hold_reg;
    d_hold_next    = d_hold_reg;
`ifdef MEM_ARB_WRCNT_EN
    wrcnt_next     = wrcnt_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (data_win) begin
          state_next     = ST_ISSUE;
          owner_next     = OWN_D;
          mem_en_next    = 1'b1;
          mem_we_next    = d_we;
          mem_addr_next  = d_addr[MW+1:2];
          mem_wdata_next = d_wdata;
          d_ack_next     = 1'b1;
          // Count only grants that actually bypass a waiting fetch.
          if (if_req) begin
            starve_next = (starve_reg == STARVE_LIM) ? starve_reg : starve_reg + 4'd1;
          end else begin
            starve_next = '0;
          end
`ifdef MEM_ARB_WRCNT_EN
          if (d_we) begin
            wrcnt_next = wrcnt_reg + 1'b1;
          end
`endif
        end else if (if_req) begin
          state_next     = ST_ISSUE;
          owner_next     = OWN_IF;
          mem_en_next    = 1'b1;
          mem_we_next    = 1'b0;
          mem_addr_next  = if_addr[MW+1:2];
          mem_wdata_next = '0;
          if_ack_next    = 1'b1;
          starve_next    = '0;
        end else begin
          starve_next = '0;
        end
      end
      ST_ISSUE: begin
        state_next = mem_we_reg ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        state_next = ST_IDLE;
        // Keep a copy so the port's rdata stays stable after the pulse.
        if (owner_reg == OWN_IF) begin
          if_hold_next = mem_rdata;
        end else begin
          d_hold_next = mem_rdata;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign if_rvalid = (state_reg == ST_RESP) && (owner_reg == OWN_IF);
  assign d_rvalid  = (state_reg == ST_RESP) && (owner_reg == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : if_hold_reg;
  assign d_rdata   = d_rvalid  ? mem_rdata : d_hold_reg;
  assign if_ack    = if_ack_reg;
  assign d_ack     = d_ack_reg;
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = (state_reg != ST_IDLE);
`ifdef MEM_ARB_WRCNT_EN
  assign led_num   = wrcnt_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int MW         = 6;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 1 << MW;
`ifdef MEM_ARB_WRCNT_EN
  localparam int CNT_W      = 8;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req, if_ack, if_rvalid;
  logic [31:0]   if_addr, if_rdata;
  logic          d_req, d_we, d_ack, d_rvalid;
  logic [31:0]   d_addr, d_wdata, d_rdata;
  logic          mem_en, mem_we, busy;
  logic [MW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
`ifdef MEM_ARB_WRCNT_EN
  logic [CNT_W-1:0] led_num;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.MW(MW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_ARB_WRCNT_EN
    , .led_num(led_num)
`endif
  );

  // RAM macro stand-in: registered read, 1-cycle latency.
  logic [31:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct { int due; bit side; logic [MW-1:0] addr; bit we; logic [31:0] wdata; } ack_t;
  typedef struct { int due; bit side; logic [31:0] data; } rd_t;
  typedef struct { bit d; int cyc; } log_t;

  ack_t exp_ack_q[$];
  rd_t  exp_rd_q[$];
  log_t grant_log[$];
  logic [31:0] ref_mem [0:DEPTH-1];
  int cyc = 0, m_timer = 0, m_starve = 0, m_wrcnt = 0;
  bit take_d, take_i;
  logic [MW-1:0] m_idx;

  // The arbiter is free to sample requests whenever no earlier grant still
  // occupies it: a write keeps it for one further edge, a read for two.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_timer = 0; m_starve = 0; m_wrcnt = 0;
      exp_ack_q.delete(); exp_rd_q.delete();
    end else begin
      cyc++;
      if (m_timer > 0) begin
        m_timer--;
      end else begin
        take_d = d_req && !(if_req && m_starve == STARVE_MAX);
        take_i = !take_d && if_req;
        if (take_d) begin
          m_idx = d_addr[MW+1:2];
          exp_ack_q.push_back('{cyc, 1'b1, m_idx, d_we, d_wdata});
          if (d_we) begin
            ref_mem[m_idx] = d_wdata;
            m_wrcnt++;
            m_timer = 1;
          end else begin
            exp_rd_q.push_back('{cyc + 1, 1'b1, ref_mem[m_idx]});
            m_timer = 2;
          end
          m_starve = if_req ? ((m_starve < STARVE_MAX) ? m_starve + 1 : m_starve) : 0;
        end else if (take_i) begin
          m_idx = if_addr[MW+1:2];
          exp_ack_q.push_back('{cyc, 1'b0, m_idx, 1'b0, 32'h0});
          exp_rd_q.push_back('{cyc + 1, 1'b0, ref_mem[m_idx]});
          m_timer = 2;
          m_starve = 0;
        end else begin
          m_starve = 0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  ack_t ea;
  rd_t  er;
  logic [31:0] last_if = '0, last_d = '0;

  always @(negedge clk) begin
    if (rst) begin
      last_if = '0; last_d = '0;
    end else begin
      check("busy", 128'(busy), 128'(m_timer > 0));
      if (exp_ack_q.size() > 0 && exp_ack_q[0].due == cyc) begin
        ea = exp_ack_q.pop_front();
        check("ack", 128'({if_ack, d_ack, mem_en, mem_we, mem_addr, mem_wdata}),
                     128'({!ea.side, ea.side, 1'b1, ea.we, ea.addr, ea.wdata}));
        grant_log.push_back('{d_ack, cyc});
        $display("txn cyc=%0d side=%s we=%0b word=%0d wdata=%08h",
                 cyc, ea.side ? "D" : "IF", ea.we, ea.addr, ea.wdata);
`ifdef MEM_ARB_WRCNT_EN
        check("led_num", 128'(led_num), 128'(CNT_W'(m_wrcnt)));
`endif
      end else begin
        check("no_ack", 128'({if_ack, d_ack, mem_en, mem_we}), 128'(0));
      end
      if (exp_rd_q.size() > 0 && exp_rd_q[0].due == cyc) begin
        er = exp_rd_q.pop_front();
        if (er.side) begin
          check("d_read", 128'({if_rvalid, d_rvalid, d_rdata, if_rdata}),
                          128'({2'b01, er.data, last_if}));
          last_d = er.data;
        end else begin
          check("if_read", 128'({if_rvalid, d_rvalid, if_rdata, d_rdata}),
                           128'({2'b10, er.data, last_d}));
          last_if = er.data;
        end
      end else begin
        check("no_rvalid", 128'({if_rvalid, d_rvalid}), 128'(0));
      end
    end
  end

  // ---------------- requesters ----------------
  typedef struct { int gap; logic [31:0] addr; } freq_t;
  typedef struct { int gap; bit we; logic [31:0] addr; logic [31:0] wdata; } dreq_t;
  freq_t f_q[$];
  dreq_t d_q[$];
  int f_gap = -1, d_gap = -1;

  initial begin
    if_req = 1'b0; if_addr = '0;
    forever begin
      @(negedge clk);
      if (if_req && if_ack) if_req = 1'b0;
      if (!if_req && f_q.size() > 0) begin
        if (f_gap < 0) f_gap = f_q[0].gap;
        if (f_gap == 0) begin
          if_addr = f_q[0].addr; if_req = 1'b1;
          void'(f_q.pop_front()); f_gap = -1;
        end else f_gap--;
      end
    end
  end

  initial begin
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    forever begin
      @(negedge clk);
      if (d_req && d_ack) d_req = 1'b0;
      if (!d_req && d_q.size() > 0) begin
        if (d_gap < 0) d_gap = d_q[0].gap;
        if (d_gap == 0) begin
          d_we = d_q[0].we; d_addr = d_q[0].addr; d_wdata = d_q[0].wdata; d_req = 1'b1;
          void'(d_q.pop_front()); d_gap = -1;
        end else d_gap--;
      end
    end
  end

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (n < 3000 && !(f_q.size() == 0 && d_q.size() == 0 && !if_req && !d_req &&
                         m_timer == 0 && exp_ack_q.size() == 0 && exp_rd_q.size() == 0)) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (n >= 3000) begin
      mismatched++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", tag, n);
    end
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  int idx0, k;
  bit exp_order [0:9];
  logic [31:0] v;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      ram[i] = v; ref_mem[i] = v;
    end
    ram[3] = 32'h20030000; ref_mem[3] = 32'h20030000;

    #1;
    check("reset_state", 128'({if_ack, d_ack, if_rvalid, d_rvalid, mem_en, mem_we, busy, mem_addr, mem_wdata}), 128'(0));
`ifdef MEM_ARB_WRCNT_EN
    check("reset_led", 128'(led_num), 128'(0));
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // fetch only
    f_q.push_back('{0, 32'h0000000C});
    wait_idle("fetch");

    // store then load of the same word
    d_q.push_back('{0, 1'b1, 32'h00000014, 32'hDEADBEEF});
    d_q.push_back('{0, 1'b0, 32'h00000014, 32'h0});
    wait_idle("store_load");

    // sustained contention: data wins STARVE_MAX times, then fetch is forced
    idx0 = grant_log.size();
    for (int i = 0; i < 10; i++) begin
      f_q.push_back('{0, 32'h100 + 32'(4 * i)});
      d_q.push_back('{0, 1'b0, 32'h40 + 32'(4 * i), 32'h0});
    end
    wait_idle("contention");
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) check($sformatf("grant_order_%0d", i), 128'(grant_log[idx0 + i].d), 128'(exp_order[i]));

    // simultaneous single requests: data first, fetch three cycles later
    idx0 = grant_log.size();
    f_q.push_back('{0, 32'h00000010});
    d_q.push_back('{0, 1'b0, 32'h00000018, 32'h0});
    wait_idle("simultaneous");
    check("simul_first_is_d", 128'(grant_log[idx0].d), 128'(1));
    check("simul_second_is_if", 128'(grant_log[idx0 + 1].d), 128'(0));
    check("simul_gap", 128'(grant_log[idx0 + 1].cyc - grant_log[idx0].cyc), 128'(3));

    // reset during the ISSUE cycle of a fetch
    f_q.push_back('{0, 32'h0000000C});
    k = 0;
    while (!if_ack && k < 50) begin @(negedge clk); k++; end
    check("reset_wait_ack", 128'(k < 50), 128'(1));
    #1 rst = 1'b1;
    #1;
    check("reset_mid", 128'({if_ack, d_ack, if_rvalid, d_rvalid, mem_en, mem_we, busy, mem_addr, mem_wdata}), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    f_q.push_back('{0, 32'h0000000C});
    wait_idle("after_reset");

    // address wrap: 0x104 lands on word 1, read back through alias 0x4
    d_q.push_back('{0, 1'b1, 32'h00000104, 32'hA5A50001});
    d_q.push_back('{1, 1'b0, 32'hFFFFFF04, 32'h0});
    wait_idle("wrap");

`ifdef MEM_ARB_WRCNT_EN
    v = 32'(led_num);
    for (int i = 0; i < 256; i++) d_q.push_back('{0, 1'b1, $urandom, $urandom});
    wait_idle("led_wrap");
    check("led_wrap", 128'(led_num), 128'(CNT_W'(v)));
`endif

    // randomized traffic on both ports
    for (int i = 0; i < 150; i++) begin
      f_q.push_back('{int'($urandom_range(0, 3)), $urandom});
      d_q.push_back('{int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom});
    end
    wait_idle("random");

    check("ack_queue_empty", 128'(exp_ack_q.size()), 128'(0));
    check("rd_queue_empty", 128'(exp_rd_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
